// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall detection, taken-branch flush
// window sequencing, and saturating debug counters for stalls and flushes.
//
// state | meaning
// RUN   | normal issue; only a taken-branch pulse flushes
// FLUSH | flush window still open after a taken branch, fcnt cycles remain
module hazard_ctrl_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             lw_bubble_o,
    output logic             b_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FC_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic       FC_MULTI  = (FLUSH_CYCLES > 1);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       hz, fl;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        hz           = 1'b0;
        fl           = 1'b0;
        lw_bubble_o  = 1'b0;
        b_bubble_o   = 1'b0;
        ifid_flush_o = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;

        // Strobes are forced to their idle values while reset is held.
        if (!rst_i) begin
            hz = idex_memread_i && (idex_rt_i != 5'd0) &&
                 ((idex_rt_i == ifid_rs_i) ||
                  (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
            fl = branch_taken_i || (state == FLUSH);
        end

        b_bubble_o   = fl;
        ifid_flush_o = fl;
        lw_bubble_o  = hz && !fl;
        pc_write_o   = !lw_bubble_o;
        ifid_write_o = !lw_bubble_o;

        // A new taken branch always restarts the window, even mid-flush.
        if (branch_taken_i) begin
            state_nxt = FC_MULTI ? FLUSH : RUN;
            fcnt_nxt  = FC_RELOAD;
        end else if (state == FLUSH) begin
            if (fcnt == 3'd0) begin
                state_nxt = RUN;
            end else begin
                fcnt_nxt = fcnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (lw_bubble_o && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (branch_taken_i && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push expected
// strobes/counters; a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [4:0]    ifid_rs_i = '0;
    logic [4:0]    ifid_rt_i = '0;
    logic          ifid_uses_rt_i = 1'b0;
    logic          idex_memread_i = 1'b0;
    logic [4:0]    idex_rt_i = '0;
    logic          branch_taken_i = 1'b0;
    logic          pc_write_o, ifid_write_o, ifid_flush_o, lw_bubble_o, b_bubble_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o;

    hazard_ctrl_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .branch_taken_i (branch_taken_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .lw_bubble_o    (lw_bubble_o),
        .b_bubble_o     (b_bubble_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          lw;
        logic          bb;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input string field, input int act, input int exp);
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", name, field, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            chk(e.name, "lw_bubble",  int'(lw_bubble_o),  int'(e.lw));
            chk(e.name, "b_bubble",   int'(b_bubble_o),   int'(e.bb));
            chk(e.name, "ifid_flush", int'(ifid_flush_o), int'(e.bb));
            chk(e.name, "pc_write",   int'(pc_write_o),   int'(!e.lw));
            chk(e.name, "ifid_write", int'(ifid_write_o), int'(!e.lw));
            chk(e.name, "stall_cnt",  int'(stall_cnt_o),  int'(e.sc));
            chk(e.name, "flush_cnt",  int'(flush_cnt_o),  int'(e.fc));
        end
    end

    // One vector per cycle: inputs driven 1 time unit after the rising edge.
    task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic uses, input logic memrd, input logic [4:0] idrt,
                         input logic br, input logic lw, input logic bb,
                         input int sc, input int fc, input string name);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i          = rst;
        ifid_rs_i      = rs;
        ifid_rt_i      = rt;
        ifid_uses_rt_i = uses;
        idex_memread_i = memrd;
        idex_rt_i      = idrt;
        branch_taken_i = br;
        e.lw   = lw;
        e.bb   = bb;
        e.sc   = CW'(sc);
        e.fc   = CW'(fc);
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        //    rst rs  rt uses mrd idrt br  lw bb  sc fc
        apply(1, 0,  0, 0,  0,  0,  0,  0, 0,  0, 0, "rst_idle");
        apply(1, 5,  0, 0,  1,  5,  1,  0, 0,  0, 0, "rst_masks");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0,  0, 0, "idle");
        apply(0, 5,  0, 0,  1,  5,  0,  1, 0,  0, 0, "lu_rs");
        apply(0, 5,  0, 0,  0,  5,  0,  0, 0,  1, 0, "lu_rs_release");
        apply(0, 0,  0, 0,  1,  0,  0,  0, 0,  1, 0, "r0_no_hz");
        apply(0, 0,  7, 0,  1,  7,  0,  0, 0,  1, 0, "rt_unused");
        apply(0, 0,  7, 1,  1,  7,  0,  1, 0,  1, 0, "rt_used");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0,  2, 0, "idle2");
        apply(0, 0,  0, 0,  0,  0,  1,  0, 1,  2, 0, "br_n");
        apply(0, 5,  0, 0,  1,  5,  0,  0, 1,  2, 1, "br_n1_hz");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0,  2, 1, "br_n2");
        apply(0, 5,  0, 0,  1,  5,  1,  0, 1,  2, 1, "br_and_hz");
        apply(0, 0,  0, 0,  0,  0,  1,  0, 1,  2, 2, "br_again");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 1,  2, 3, "br_ext");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0,  2, 3, "br_ext_end");
        apply(0, 0,  0, 0,  0,  0,  1,  0, 1,  2, 3, "br_pre_rst");
        apply(1, 5,  0, 0,  1,  5,  0,  0, 0,  0, 0, "rst_midflush");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0,  0, 0, "post_rst");
        for (int i = 0; i < 20; i++)
            apply(0, 5, 0, 0, 1, 5, 0, 1, 0, (i < 15) ? i : 15, 0, "sat_stall");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0, 15, 0, "sat_stall_hold");
        for (int i = 0; i < 18; i++)
            apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 15, (i < 15) ? i : 15, "sat_flush");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 1, 15, 15, "sat_flush_tail");
        apply(0, 0,  0, 0,  0,  0,  0,  0, 0, 15, 15, "sat_flush_hold");

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(posedge clk_i);
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Produces the bubble and stall controls consumed by the ID/EX pipeline register: `lw_bubble_o` and `b_bubble_o`.
- Also drives PC write-enable and the IF/ID write/flush strobes.
- Detects load-use hazards between IF/ID and ID/EX.
- Sequences a multi-cycle flush window after a taken branch resolves late in the pipe.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- FLUSH_CYCLES, 2, consecutive cycles `b_bubble_o`/`ifid_flush_o` stay high per taken branch (legal 1..7).
- CNT_W, 16, width of the event counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_uses_rt_i  in  1  IF/ID instruction reads rt as a source (R-type, store, branch).
- idex_memread_i  in  1  instruction in ID/EX is a load.
- idex_rt_i  in  5  destination rt of the ID/EX instruction.
- branch_taken_i  in  1  branch resolved taken this cycle (one-cycle pulse).
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID update enable.
- ifid_flush_o  out  1  IF/ID clear to NOP.
- lw_bubble_o  out  1  insert load-use bubble into ID/EX.
- b_bubble_o  out  1  clear ID/EX for branch flush.
- stall_cnt_o  out  CNT_W  load-use stall cycles seen.
- flush_cnt_o  out  CNT_W  taken branches seen.

Behaviour:
State:
- 2-state FSM: RUN, FLUSH.
- 3-bit down-counter `fcnt`.
- Registers `stall_cnt_o` and `flush_cnt_o`.

Reset (`rst_i` high, async):
- State = RUN, `fcnt` = 0, both counters = 0.
- While `rst_i` is high: `lw_bubble_o` = 0, `b_bubble_o` = 0, `ifid_flush_o` = 0, `pc_write_o` = 1, `ifid_write_o` = 1.
- Reset asserted mid-flush aborts the window immediately.

Load-use hazard, combinational:
- hz = `idex_memread_i` & (`idex_rt_i` != 0) & ((`idex_rt_i` == `ifid_rs_i`) | (`ifid_uses_rt_i` & `idex_rt_i` == `ifid_rt_i`)).
- Register 0 never creates a hazard.

Flush active, combinational:
- fl = `branch_taken_i` | (state == FLUSH).

Outputs, Mealy, same cycle as the cause:
- `b_bubble_o` = fl; `ifid_flush_o` = fl.
- `lw_bubble_o` = hz & ~fl. A branch flush has priority; the stalled instruction is wrong-path and gets flushed anyway.
- `pc_write_o` = ~`lw_bubble_o`; `ifid_write_o` = ~`lw_bubble_o`. The PC loads the branch target while flushing.

FSM transitions:
- RUN with `branch_taken_i`: if FLUSH_CYCLES > 1, go to FLUSH with `fcnt` = FLUSH_CYCLES-2; otherwise stay in RUN.
- FLUSH with `branch_taken_i` (new taken branch): restart the window, `fcnt` = FLUSH_CYCLES-2.
- FLUSH with `fcnt` == 0: go to RUN.
- FLUSH otherwise: `fcnt` decrements.
- Total flush length per isolated taken branch is exactly FLUSH_CYCLES cycles, starting in the pulse cycle.

Counters:
- `stall_cnt_o` increments on each edge where `lw_bubble_o` = 1.
- `flush_cnt_o` increments on each edge where `branch_taken_i` = 1.
- Both saturate at all-ones and never wrap.

Latency and sustained behaviour:
- Zero-cycle (combinational) from inputs to strobes.
- One-cycle update for state and counters.
- A load-use stall lasts exactly one cycle if the ID/EX inputs then show the bubble (`memread` = 0). `hz` is re-evaluated every cycle, so back-to-back stalls occur if the inputs persist.

Test Plan:
- Reset: assert `rst_i` asynchronously mid-cycle → all bubbles/flush 0, both write enables 1, counters 0, state RUN with no clock edge.
- Load-use on rs: `idex_memread_i`=1, `idex_rt_i`=5, `ifid_rs_i`=5 for 1 cycle, then `memread`=0 → `lw_bubble_o`=1 and `pc_write_o`=`ifid_write_o`=0 that cycle only; `stall_cnt_o`=1.
- Zero-register and rt-unused cases:
  - `idex_rt_i`=0=`ifid_rs_i` → no stall.
  - `idex_rt_i`=7=`ifid_rt_i` with `ifid_uses_rt_i`=0 → no stall.
  - Same with `ifid_uses_rt_i`=1 → stall.
- Taken branch with FLUSH_CYCLES=2: pulse `branch_taken_i` at cycle N → `b_bubble_o`=`ifid_flush_o`=1 in cycles N and N+1, 0 at N+2; `flush_cnt_o`=1.
- Simultaneous events:
  - `branch_taken_i`=1 together with a load-use hazard → `b_bubble_o`=1, `lw_bubble_o`=0, `pc_write_o`=1, `stall_cnt_o` unchanged.
  - Second `branch_taken_i` pulse at N+1 → flush extends through N+2.
- Saturation: CNT_W=4, 20 stall cycles → `stall_cnt_o` holds 15.
